// File: rtl/wb_up_bridge.sv
`default_nettype none
// ============================================================================
// Module      : wb_up_bridge
// Description : Wishbone narrow-to-wide bridge. Accepts one narrow request,
//               issues it as a single lane of a wide access, and returns the
//               matching lane of read data (or an error/timeout) to the
//               narrow side.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_up_bridge #(
  parameter int AW     = 32,
  parameter int SDW    = 32,
  parameter int MDW    = 128,
  parameter int TO_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // narrow (slave-facing) port
  input  logic [AW-1:0]        i_s_wb_adr,
  input  logic [SDW/8-1:0]     i_s_wb_sel,
  input  logic [SDW-1:0]       i_s_wb_dat,
  input  logic                 i_s_wb_we,
  input  logic                 i_s_wb_cyc,
  input  logic                 i_s_wb_stb,
  output logic [SDW-1:0]       o_s_wb_dat,
  output logic                 o_s_wb_ack,
  output logic                 o_s_wb_err,
  // wide (master-facing) port
  output logic [AW-1:0]        o_m_wb_adr,
  output logic [MDW/8-1:0]     o_m_wb_sel,
  output logic [MDW-1:0]       o_m_wb_dat,
  output logic                 o_m_wb_we,
  output logic                 o_m_wb_cyc,
  output logic                 o_m_wb_stb,
  input  logic [MDW-1:0]       i_m_wb_dat,
  input  logic                 i_m_wb_ack,
  input  logic                 i_m_wb_err
);

  localparam int SSW       = SDW / 8;
  localparam int MSW       = MDW / 8;
  localparam int NLANE     = MDW / SDW;
  localparam int LW        = $clog2(MSW);
  localparam int SLW       = $clog2(SSW);
  localparam int LANE_BITS = LW - SLW;
  localparam logic [15:0] TO_LIM = TO_CYC[15:0];

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [LANE_BITS-1:0]   lane_q, lane_d;
  logic [AW-1:0]          m_adr_q, m_adr_d;
  logic [MSW-1:0]         m_sel_q, m_sel_d;
  logic [MDW-1:0]         m_dat_q, m_dat_d;
  logic                   m_we_q, m_we_d;
  logic                   m_cyc_q, m_cyc_d;
  logic [SDW-1:0]         s_dat_q, s_dat_d;
  logic                   s_ack_q, s_ack_d;
  logic                   s_err_q, s_err_d;

  // State register and all output flops; reset clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lane_q  <= '0;
      m_adr_q <= '0;
      m_sel_q <= '0;
      m_dat_q <= '0;
      m_we_q  <= 1'b0;
      m_cyc_q <= 1'b0;
      s_dat_q <= '0;
      s_ack_q <= 1'b0;
      s_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
      m_adr_q <= m_adr_d;
      m_sel_q <= m_sel_d;
      m_dat_q <= m_dat_d;
      m_we_q  <= m_we_d;
      m_cyc_q <= m_cyc_d;
      s_dat_q <= s_dat_d;
      s_ack_q <= s_ack_d;
      s_err_q <= s_err_d;
    end
  end

  // Next-state logic: capture, wide handshake with timeout/abort, response pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    m_adr_d = m_adr_q;
    m_sel_d = m_sel_q;
    m_dat_d = m_dat_q;
    m_we_d  = m_we_q;
    m_cyc_d = m_cyc_q;
    s_dat_d = s_dat_q;
    s_ack_d = 1'b0;
    s_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_s_wb_cyc && i_s_wb_stb) begin
          lane_d            = i_s_wb_adr[LW-1:SLW];
          m_adr_d           = i_s_wb_adr;
          m_adr_d[LW-1:0]   = '0;
          m_sel_d           = '0;
          m_sel_d[i_s_wb_adr[LW-1:SLW]*SSW +: SSW] = i_s_wb_sel;
          m_dat_d           = {NLANE{i_s_wb_dat}};
          m_we_d            = i_s_wb_we;
          m_cyc_d           = 1'b1;
          cnt_d             = '0;
          state_d           = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (!i_s_wb_cyc) begin
          // narrow master gave up: drop the wide cycle silently
          m_cyc_d = 1'b0;
          state_d = ST_IDLE;
        end else if (i_m_wb_err) begin
          // err wins even when ack is asserted alongside it
          m_cyc_d = 1'b0;
          s_err_d = 1'b1;
          state_d = ST_RESP;
        end else if (i_m_wb_ack) begin
          m_cyc_d = 1'b0;
          s_ack_d = 1'b1;
          if (!m_we_q) begin
            s_dat_d = i_m_wb_dat[lane_q*SDW +: SDW];
          end
          state_d = ST_RESP;
        end else if (cnt_q + 16'd1 == TO_LIM) begin
          m_cyc_d = 1'b0;
          s_err_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_s_wb_dat = s_dat_q;
  assign o_s_wb_ack = s_ack_q;
  assign o_s_wb_err = s_err_q;
  assign o_m_wb_adr = m_adr_q;
  assign o_m_wb_sel = m_sel_q;
  assign o_m_wb_dat = m_dat_q;
  assign o_m_wb_we  = m_we_q;
  assign o_m_wb_cyc = m_cyc_q;
  assign o_m_wb_stb = m_cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_up_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_up_bridge
// Description : Self-checking bench for wb_up_bridge (directed cases plus
//               randomized transactions against a behavioural model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_up_bridge;

  localparam int TO = 4;

  logic          clk;
  logic          rst_n;
  logic [31:0]   s_adr;
  logic [3:0]    s_sel;
  logic [31:0]   s_dat;
  logic          s_we, s_cyc, s_stb;
  logic [31:0]   s_rdat;
  logic          s_ack, s_err;
  logic [31:0]   m_adr;
  logic [15:0]   m_sel;
  logic [127:0]  m_wdat;
  logic          m_we, m_cyc, m_stb;
  logic [127:0]  m_rdat;
  logic          m_ack, m_err;

  int            n_checks;
  int            n_errors;
  logic [31:0]   model_sdat;

  wb_up_bridge #(.AW(32), .SDW(32), .MDW(128), .TO_CYC(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_s_wb_adr (s_adr),
    .i_s_wb_sel (s_sel),
    .i_s_wb_dat (s_dat),
    .i_s_wb_we  (s_we),
    .i_s_wb_cyc (s_cyc),
    .i_s_wb_stb (s_stb),
    .o_s_wb_dat (s_rdat),
    .o_s_wb_ack (s_ack),
    .o_s_wb_err (s_err),
    .o_m_wb_adr (m_adr),
    .o_m_wb_sel (m_sel),
    .o_m_wb_dat (m_wdat),
    .o_m_wb_we  (m_we),
    .o_m_wb_cyc (m_cyc),
    .o_m_wb_stb (m_stb),
    .i_m_wb_dat (m_rdat),
    .i_m_wb_ack (m_ack),
    .i_m_wb_err (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 = ack, 1 = err, 2 = ack+err together, 3 = no response (timeout)
  task automatic run_txn(input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input logic we,
                         input int kind, input int waits, input logic [127:0] rdat);
    int          lane;
    int          busy;
    logic [31:0] eadr;
    logic [15:0] esel;
    lane = int'((adr / 4) % 4);
    eadr = adr - (adr % 16);
    esel = 16'(sel) << (4 * lane);
    s_adr = adr; s_sel = sel; s_dat = dat; s_we = we; s_cyc = 1'b1; s_stb = 1'b1;
    @(negedge clk);
    check_eq("m_cyc_stb", {m_cyc, m_stb}, 2'b11);
    check_eq("m_adr", m_adr, eadr);
    check_eq("m_sel", m_sel, esel);
    check_eq("m_dat", m_wdat, {dat, dat, dat, dat});
    check_eq("m_we", m_we, we);
    if (kind == 3) begin
      busy = 1;
      while (m_cyc && busy < 20) begin
        @(negedge clk);
        if (m_cyc) busy++;
      end
      check_eq("timeout_cycles", busy, TO);
      check_eq("timeout_ack_err", {s_ack, s_err}, 2'b01);
    end else begin
      repeat (waits) begin
        @(negedge clk);
        check_eq("m_hold", {m_cyc, m_stb, m_we, m_adr, m_sel}, {2'b11, we, eadr, esel});
      end
      m_rdat = rdat;
      m_ack  = (kind != 1);
      m_err  = (kind != 0);
      @(negedge clk);
      m_ack = 1'b0; m_err = 1'b0;
      m_rdat = {$urandom, $urandom, $urandom, $urandom};
      check_eq("m_cyc_drop", {m_cyc, m_stb}, 2'b00);
      check_eq("resp_ack_err", {s_ack, s_err}, (kind == 0) ? 2'b10 : 2'b01);
      if (kind == 0 && !we) model_sdat = 32'(rdat >> (32 * lane));
    end
    s_cyc = 1'b0; s_stb = 1'b0;
    check_eq("s_dat", s_rdat, model_sdat);
    @(negedge clk);
    check_eq("resp_one_cycle", {s_ack, s_err}, 2'b00);
  endtask

  initial begin
    n_checks = 0; n_errors = 0; model_sdat = '0;
    rst_n = 1'b0;
    s_adr = '0; s_sel = '0; s_dat = '0; s_we = 1'b0; s_cyc = 1'b0; s_stb = 1'b0;
    m_rdat = '0; m_ack = 1'b0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs",
             {s_rdat, s_ack, s_err, m_adr, m_sel, m_wdat, m_we, m_cyc, m_stb}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // read of lane 2 with one wait state
    run_txn(32'h0000_0008, 4'hF, 32'h0, 1'b0, 0, 1,
            128'h44444444_33333333_22222222_11111111);
    check_eq("read_lane2", s_rdat, 32'h3333_3333);
    // write to lane 3, read data must not move
    run_txn(32'h0000_010C, 4'h3, 32'hDEAD_BEEF, 1'b1, 0, 0, '1);
    // no response at all -> timeout error
    run_txn(32'h0000_0020, 4'hF, 32'h0, 1'b0, 3, 0, '0);
    // ack and err together -> error, data unchanged
    run_txn(32'h0000_0004, 4'hF, 32'h0, 1'b0, 2, 2, '1);
    // ack arriving in the expiry cycle still wins
    run_txn(32'h0000_0034, 4'hF, 32'h0, 1'b0, 0, TO - 1,
            128'hAAAA0003_BBBB0002_CCCC0001_DDDD0000);

    // wide responses while idle are ignored
    m_ack = 1'b1; m_rdat = '1;
    @(negedge clk);
    m_ack = 1'b0;
    check_eq("idle_ack_ignored", {s_ack, s_err, m_cyc, s_rdat}, {3'b000, model_sdat});

    // asynchronous reset in the middle of a transaction
    s_adr = 32'h0000_0008; s_sel = 4'hF; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset",
             {s_rdat, s_ack, s_err, m_adr, m_sel, m_wdat, m_we, m_cyc, m_stb}, '0);
    model_sdat = '0;
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h0000_0000, 4'hF, 32'h0, 1'b0, 0, 0,
            128'h0000_0000_0000_0000_0000_0000_1234_5678);

    // narrow abort during BUSY
    s_adr = 32'h0000_0004; s_sel = 4'hF; s_we = 1'b0; s_cyc = 1'b1; s_stb = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", m_cyc, 1'b1);
    s_cyc = 1'b0; s_stb = 1'b0;
    @(negedge clk);
    check_eq("abort_drop", {m_cyc, m_stb, s_ack, s_err}, 4'b0000);
    @(negedge clk);
    check_eq("abort_silent", {s_ack, s_err, s_rdat}, {2'b00, model_sdat});

    // back-to-back reads of lanes 0 and 1
    run_txn(32'h0000_0000, 4'hF, 32'h0, 1'b0, 0, 0,
            128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    check_eq("b2b_lane0", s_rdat, 32'h0A0A_0A0A);
    run_txn(32'h0000_0004, 4'hF, 32'h0, 1'b0, 0, 0,
            128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    check_eq("b2b_lane1", s_rdat, 32'h0B0B_0B0B);

    // randomized transactions
    for (int i = 0; i < 40; i++) begin
      run_txn($urandom, 4'($urandom_range(1, 15)), $urandom, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3)),
              int'($urandom_range(0, TO - 1)),
              {$urandom, $urandom, $urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
